prio_encoder_rr: RTL and testbench

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

---
 rtl/prio_encoder_rr.sv | 119 +++++++++++
 tb/tb_prio_encoder_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: priority encoder with a single-entry registered output stage.
//
// Encodes the request vector x into the index y of the winning request. In
// MODE 0 the highest set bit wins. In MODE 1 a round-robin pointer selects the
// first set bit at or above the pointer, wrapping past N-1 back to 0. After a
// nonzero request wins, the pointer advances to just past the winner.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   x          request vector, sampled on in_valid && in_ready
//   in_valid   x is valid this cycle
//   in_ready   block can accept x this cycle (combinational)
//   y          encoded index of the winning request
//   none       accepted vector was all zeros (y is then 0)
//   out_valid  y/none hold a result
//   out_ready  consumer takes the result this cycle
module prio_encoder_rr #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = $clog2(N),
    parameter int unsigned MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y,
    output logic         none,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [W:0]   NumReq  = (W + 1)'(N);
    localparam logic [W-1:0] LastIdx = W'(N - 1);

    logic [W-1:0]   p_q;
    logic [W-1:0]   y_q;
    logic           none_q;
    logic           out_valid_q;

    logic           accept;
    logic           any;
    logic [W-1:0]   hi_idx;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   rr_off;
    logic [W:0]     rr_sum;
    logic [W-1:0]   win;
    logic [W-1:0]   p_next;

    // Single-entry output register: free whenever it is empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        any = |x;

        // Fixed priority: later (higher) set bits overwrite earlier ones.
        hi_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (x[i]) begin
                hi_idx = W'(i);
            end
        end

        // Round-robin: rotate x so the pointer position lands at bit 0, take
        // the lowest set bit, then map the offset back to an absolute index.
        dbl    = {x, x} >> p_q;
        rot    = dbl[N-1:0];
        rr_off = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rr_off = W'(i);
            end
        end
        rr_sum = {1'b0, p_q} + {1'b0, rr_off};
        if (rr_sum >= NumReq) begin
            rr_sum = rr_sum - NumReq;
        end

        if (!any) begin
            win = '0;
        end else if (MODE == 0) begin
            win = hi_idx;
        end else begin
            win = rr_sum[W-1:0];
        end

        // Explicit wrap so non-power-of-two N never points past N-1.
        p_next = (win == LastIdx) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            none_q      <= 1'b0;
            p_q         <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                y_q         <= win;
                none_q      <= !any;
                // Pointer only moves on a real winner; MODE 0 keeps it at 0.
                if (MODE == 1 && any) begin
                    p_q <= p_next;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign y         = y_q;
    assign none      = none_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (N=4 fixed, N=8 round-robin,
// N=5 round-robin) driven by directed steps; results predicted by a reference
// model are queued on accept and compared when the DUT presents them.
module tb_prio_encoder_rr;

    typedef struct {
        int y;
        bit none;
    } res_t;

    logic clk;
    logic rst;

    logic [3:0] x_a;  logic iv_a, ir_a, ov_a, or_a, none_a;  logic [1:0] y_a;
    logic [7:0] x_b;  logic iv_b, ir_b, ov_b, or_b, none_b;  logic [2:0] y_b;
    logic [4:0] x_c;  logic iv_c, ir_c, ov_c, or_c, none_c;  logic [2:0] y_c;

    res_t sb [3][$];
    int   mp [3];
    int   total;
    int   bad;

    prio_encoder_rr #(.N(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .x(x_a), .in_valid(iv_a), .in_ready(ir_a),
        .y(y_a), .none(none_a), .out_valid(ov_a), .out_ready(or_a)
    );
    prio_encoder_rr #(.N(8), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .x(x_b), .in_valid(iv_b), .in_ready(ir_b),
        .y(y_b), .none(none_b), .out_valid(ov_b), .out_ready(or_b)
    );
    prio_encoder_rr #(.N(5), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .x(x_c), .in_valid(iv_c), .in_ready(ir_c),
        .y(y_c), .none(none_c), .out_valid(ov_c), .out_ready(or_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(int c);
        return (c == 0) ? 4 : (c == 1) ? 8 : 5;
    endfunction

    function automatic int mode_of(int c);
        return (c == 0) ? 0 : 1;
    endfunction

    function automatic bit bit_at(logic [63:0] v, int i);
        logic [5:0] k;
        k = i[5:0];
        return v[k];
    endfunction

    // Reference model; advances the model pointer like the hardware should.
    function automatic res_t model(int c, logic [63:0] xv);
        res_t r;
        int   n;
        n      = n_of(c);
        r.y    = 0;
        r.none = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (bit_at(xv, i)) r.none = 1'b0;
        end
        if (!r.none) begin
            if (mode_of(c) == 0) begin
                for (int i = 0; i < n; i++) begin
                    if (bit_at(xv, i)) r.y = i;
                end
            end else begin
                for (int k = n - 1; k >= 0; k--) begin
                    if (bit_at(xv, (mp[c] + k) % n)) r.y = (mp[c] + k) % n;
                end
                mp[c] = (r.y + 1) % n;
            end
        end
        return r;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic drive(int c, logic [63:0] xv, bit iv, bit ordy);
        case (c)
            0: begin x_a = xv[3:0]; iv_a = iv; or_a = ordy; end
            1: begin x_b = xv[7:0]; iv_b = iv; or_b = ordy; end
            default: begin x_c = xv[4:0]; iv_c = iv; or_c = ordy; end
        endcase
    endtask

    task automatic sample(int c, output int ov, output int yv, output int nn, output int ir);
        case (c)
            0: begin ov = int'(ov_a); yv = int'(y_a); nn = int'(none_a); ir = int'(ir_a); end
            1: begin ov = int'(ov_b); yv = int'(y_b); nn = int'(none_b); ir = int'(ir_b); end
            default: begin
                ov = int'(ov_c); yv = int'(y_c); nn = int'(none_c); ir = int'(ir_c);
            end
        endcase
    endtask

    // One cycle on channel c, starting and ending at a falling edge. The
    // channel is parked (in_valid=0, out_ready=0) afterwards so it holds still.
    task automatic step(int c, logic [63:0] xv, bit iv, bit ordy);
        int   ov, yv, nn, ir;
        bit   exp_ir;
        bit   acc;
        res_t r;
        drive(c, xv, iv, ordy);
        #1;
        exp_ir = (sb[c].size() == 0) || ordy;
        sample(c, ov, yv, nn, ir);
        chk($sformatf("c%0d_in_ready", c), ir, int'(exp_ir));
        acc = iv && exp_ir;
        @(posedge clk);
        if (sb[c].size() != 0 && ordy) void'(sb[c].pop_front());
        if (acc) begin
            r = model(c, xv);
            sb[c].push_back(r);
        end
        @(negedge clk);
        sample(c, ov, yv, nn, ir);
        chk($sformatf("c%0d_out_valid", c), ov, int'(sb[c].size() != 0));
        if (sb[c].size() != 0) begin
            chk($sformatf("c%0d_y", c), yv, sb[c][0].y);
            chk($sformatf("c%0d_none", c), nn, int'(sb[c][0].none));
        end
        drive(c, xv, 1'b0, 1'b0);
    endtask

    // Reset with optional pending traffic on every channel; reset must win.
    task automatic do_reset(bit traffic);
        int ov, yv, nn, ir;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) drive(c, '1, traffic, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(c, '0, 1'b0, 1'b0);
            sb[c].delete();
            mp[c] = 0;
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            sample(c, ov, yv, nn, ir);
            chk($sformatf("c%0d_rst_out_valid", c), ov, 0);
            chk($sformatf("c%0d_rst_y", c), yv, 0);
            chk($sformatf("c%0d_rst_none", c), nn, 0);
            chk($sformatf("c%0d_rst_in_ready", c), ir, 1);
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int c = 0; c < 3; c++) drive(c, '0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset(1'b0);

        // Fixed priority, N=4: full sweep at full throughput.
        for (int v = 0; v < 16; v++) step(0, 64'(v), 1'b1, 1'b1);

        // Round-robin, N=8: alternating winners on a held two-bit vector.
        for (int i = 0; i < 4; i++) step(1, 64'h81, 1'b1, 1'b1);
        // Move pointer to 5, then all-zero vector must leave it there.
        step(1, 64'h10, 1'b1, 1'b1);
        step(1, 64'h00, 1'b1, 1'b1);
        step(1, 64'h21, 1'b1, 1'b1);
        step(1, 64'h10, 1'b1, 1'b1);
        step(1, 64'h00, 1'b1, 1'b1);
        step(1, 64'h01, 1'b1, 1'b1);
        step(1, 64'h03, 1'b1, 1'b1);

        // Stall: result y=3 held for three cycles while new requests bounce.
        step(1, 64'h08, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 64'hff, 1'b1, 1'b0);
        step(1, 64'h40, 1'b1, 1'b1);
        step(1, 64'h00, 1'b0, 1'b1);

        // Round-robin, N=5: pointer at 4, winner 4 wraps the pointer to 0.
        step(2, 64'h08, 1'b1, 1'b1);
        step(2, 64'h11, 1'b1, 1'b1);
        step(2, 64'h11, 1'b1, 1'b1);
        step(2, 64'h10, 1'b1, 1'b1);
        step(2, 64'h10, 1'b1, 1'b1);

        // Mixed random traffic with random backpressure on every channel.
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 3; c++) begin
                logic [63:0] xv;
                xv = {$urandom, $urandom};
                if ($urandom_range(0, 4) == 0) xv = '0;
                step(c, xv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Reset while a result is stalled; it must be discarded.
        step(1, 64'h30, 1'b1, 1'b1);
        step(1, 64'h01, 1'b1, 1'b0);
        do_reset(1'b1);
        step(1, 64'h81, 1'b1, 1'b1);
        step(2, 64'h1f, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
